huff_stream_checker: RTL and testbench
======================================

Name: huff_stream_checker

Overview:
- Synthesizable on-chip stimulus/response engine for the Huffman-coding pipeline.
- Replays an image from an external image RAM into the DUT stream input and applies a programmable `out_stop` backpressure pattern.
- Compares every accepted DUT output word against a golden RAM, then reports pass/fail, error count, first-error index and watchdog timeout.
- Sits beside the DUT in FPGA bring-up builds, in place of the simulation-only pattern.

Parameters:
- PIC_SIZE, 64, image edge length; FEED_WORDS = PIC_SIZE*PIC_SIZE.
- DIN_W, 8, pixel width.
- DOUT_W, 15, DUT output word width.
- IN_ADDR_W, 12, image RAM address width, at least log2(FEED_WORDS).
- OUT_WORDS, 8192, expected output word count (2*PIC_SIZE*PIC_SIZE).
- OUT_ADDR_W, 13, golden RAM address width.
- START_DELAY, 3, cycles from `go` to `dut_start`.
- STALL_PERIOD, 16, periodic stall period (cycles).
- STALL_LEN, 4, stall-high cycles per period (< STALL_PERIOD).
- TIMEOUT_CYC, 65535, idle cycles tolerated before timeout.
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- go  in  1  one-cycle pulse: start a run (ignored unless IDLE or DONE)
- stall_mode  in  2  0 none, 1 periodic, 2 LFSR random, 3 treated as 0; sampled on `go`
- img_addr  out  IN_ADDR_W  image RAM read address
- img_rd_data  in  DIN_W  image RAM data, 1-cycle read latency
- gold_addr  out  OUT_ADDR_W  golden RAM read address
- gold_rd_data  in  DOUT_W  golden RAM data, 1-cycle read latency
- dut_start  out  1  start pulse to DUT
- axis_enable  out  1  input-stream valid to DUT
- s_axis_data  out  DIN_W  pixel to DUT
- out_stop  out  1  output backpressure to DUT
- odata  in  DOUT_W  DUT output word
- o_valid  in  1  DUT output valid
- end_flag  in  1  DUT end-of-image indication
- busy  out  1  run in progress
- done  out  1  run finished, held until next `go`
- pass  out  1  valid when `done`
- timeout  out  1  watchdog fired
- err_count  out  ERR_W  mismatches plus extra beats, saturating
- first_err_idx  out  OUT_ADDR_W  index of first mismatch
- out_count  out  OUT_ADDR_W+1  accepted output beats

Behaviour:
- Reset: every output 0; FSM = IDLE; LFSR = 16'hACE1.
- FSM states: IDLE, WAIT, FEED, DRAIN, FLUSH, DONE.
- IDLE/DONE + `go`:
  - clears all counters and status, latches `stall_mode`;
  - `busy` = 1, `done` = 0;
  - enters WAIT.
- WAIT:
  - counts START_DELAY cycles;
  - `dut_start` = 1 for exactly the last WAIT cycle, then FEED.
- FEED:
  - `img_addr` = feed counter k, k = 0..FEED_WORDS-1, one address per cycle;
  - `axis_enable` and `s_axis_data` are registered and trail the address by 1 cycle, so beat k appears on cycle k+1 with `s_axis_data` = RAM[k];
  - after the last address → DRAIN. The final beat is still presented in the first DRAIN cycle; `axis_enable` drops the cycle after.
- Output acceptance (WAIT/FEED/DRAIN):
  - a beat is accepted when `o_valid` && !`out_stop` in the same cycle;
  - on accept: `gold_addr` = `out_count` (combinational), `odata` is registered, `out_count` += 1.
- Compare stage, one cycle after accept:
  - registered `odata` !== `gold_rd_data` → `err_count` += 1; on the first error, `first_err_idx` = index.
  - accept with `out_count` ≥ OUT_WORDS → counted as an error (extra beat); `gold_addr` holds OUT_WORDS-1.
  - `err_count` saturates at all-ones.
- `out_stop` generation (registered, active only while `busy`):
  - mode 1: high when (cycle mod STALL_PERIOD) ≥ STALL_PERIOD-STALL_LEN;
  - mode 2: high when lfsr[1:0]==2'b11; Fibonacci LFSR with taps 16,14,13,11, stepped every cycle;
  - otherwise 0.
- Watchdog:
  - counter resets on any accept and on entering DRAIN;
  - reaching TIMEOUT_CYC in FEED/DRAIN → `timeout` = 1, go to FLUSH.
- DRAIN → FLUSH when `end_flag` = 1, or when `out_count` == OUT_WORDS.
- FLUSH:
  - one cycle so the pending compare retires;
  - then DONE: `busy` = 0, `done` = 1, `pass` = (`err_count`==0 && `out_count`==OUT_WORDS && !`timeout`).
- `end_flag` during WAIT/FEED: recorded, and the transition is taken once DRAIN is reached.
- Accept and `end_flag` in the same cycle: the beat is counted before FLUSH.
- `go` while `busy`: ignored.
- Async reset mid-run: immediate return to IDLE with all outputs 0.

Decomposition:
- Package `huff_chk_pkg`:
  - FSM state enum;
  - stall-mode localparams (STALL_NONE, STALL_PERIODIC, STALL_LFSR);
  - LFSR seed and tap constant.
- Sub-module `stall_gen`: mode, period/len counter and LFSR → registered `out_stop`, with an enable input tied to `busy`.

Test Plan (PIC_SIZE=4, OUT_WORDS=32, golden = DUT model):
- Mode 0, DUT model produces 32 correct words → `done`=1, `pass`=1, `err_count`=0, `out_count`=32; `dut_start` high exactly on cycle 3 after `go`.
- Mode 0, word 5 corrupted (XOR 1) → `err_count`=1, `first_err_idx`=5, `pass`=0.
- Mode 1, STALL_PERIOD=8, STALL_LEN=3 → `out_stop` high 3 of every 8 cycles; no beat accepted while high; `pass`=1, `out_count`=32.
- Mode 2, DUT emits back-to-back `o_valid` → accepted beats match golden in order; `pass`=1.
- DUT stops after 20 words, TIMEOUT_CYC=50 → `timeout`=1, `out_count`=20, `pass`=0, `done` within 52 cycles of the last accept.
- DUT emits 33 words before `end_flag` → `err_count`=1, `pass`=0; `rst_n` pulsed mid-FEED → all outputs 0 next cycle, and a new `go` restarts cleanly.

Source files
------------

// File: rtl/huff_chk_pkg.sv
// Shared types and constants for the Huffman stream checker.
package huff_chk_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_FEED,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } chk_state_e;

    localparam logic [1:0] STALL_NONE     = 2'd0;
    localparam logic [1:0] STALL_PERIODIC = 2'd1;
    localparam logic [1:0] STALL_LFSR     = 2'd2;

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/huff_stream_checker_stall_gen.sv
// Output backpressure generator: periodic or LFSR-random out_stop, registered.
module stall_gen
    import huff_chk_pkg::*;
#(
    parameter int unsigned STALL_PERIOD = 16,
    parameter int unsigned STALL_LEN    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] mode,
    output logic       out_stop
);

    localparam int unsigned CNT_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STALL_PERIOD - 1);
    localparam logic [CNT_W-1:0] HIGH_FROM = CNT_W'(STALL_PERIOD - STALL_LEN);

    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      lfsr_q;
    logic             stop_q;
    logic             stop_d;

    always_comb begin
        stop_d = 1'b0;
        case (mode)
            STALL_NONE:     stop_d = 1'b0;
            STALL_PERIODIC: stop_d = (cnt_q >= HIGH_FROM);
            STALL_LFSR:     stop_d = &lfsr_q[1:0];
            default:        stop_d = 1'b0;
        endcase
        stop_d = stop_d && en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            lfsr_q <= LFSR_SEED;
            stop_q <= 1'b0;
        end else begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
            stop_q <= stop_d;
            if (!en || cnt_q == CNT_LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign out_stop = stop_q;

endmodule

// File: rtl/huff_stream_checker.sv
// On-chip stimulus/response checker: replays an image into the Huffman DUT and
// compares every accepted output word against a golden RAM.
module huff_stream_checker
    import huff_chk_pkg::*;
#(
    parameter int unsigned PIC_SIZE     = 64,
    parameter int unsigned DIN_W        = 8,
    parameter int unsigned DOUT_W       = 15,
    parameter int unsigned IN_ADDR_W    = 12,
    parameter int unsigned OUT_WORDS    = 8192,
    parameter int unsigned OUT_ADDR_W   = 13,
    parameter int unsigned START_DELAY  = 3,
    parameter int unsigned STALL_PERIOD = 16,
    parameter int unsigned STALL_LEN    = 4,
    parameter int unsigned TIMEOUT_CYC  = 65535,
    parameter int unsigned ERR_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [1:0]            stall_mode,
    output logic [IN_ADDR_W-1:0]  img_addr,
    input  logic [DIN_W-1:0]      img_rd_data,
    output logic [OUT_ADDR_W-1:0] gold_addr,
    input  logic [DOUT_W-1:0]     gold_rd_data,
    output logic                  dut_start,
    output logic                  axis_enable,
    output logic [DIN_W-1:0]      s_axis_data,
    output logic                  out_stop,
    input  logic [DOUT_W-1:0]     odata,
    input  logic                  o_valid,
    input  logic                  end_flag,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [ERR_W-1:0]      err_count,
    output logic [OUT_ADDR_W-1:0] first_err_idx,
    output logic [OUT_ADDR_W:0]   out_count
);

    localparam int unsigned FEED_WORDS = PIC_SIZE * PIC_SIZE;
    localparam int unsigned CNT_W = OUT_ADDR_W + 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned WT_W  = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    localparam logic [IN_ADDR_W-1:0]  FEED_LAST = IN_ADDR_W'(FEED_WORDS - 1);
    localparam logic [CNT_W-1:0]      OUT_FULL  = CNT_W'(OUT_WORDS);
    localparam logic [OUT_ADDR_W-1:0] GOLD_LAST = OUT_ADDR_W'(OUT_WORDS - 1);
    localparam logic [WD_W-1:0]       WD_LIMIT  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WT_W-1:0]       WT_LAST   = WT_W'(START_DELAY - 1);

    chk_state_e            state_q;
    logic [1:0]            mode_q;
    logic [WT_W-1:0]       wait_q;
    logic [IN_ADDR_W-1:0]  feed_q;
    logic [WD_W-1:0]       wd_q;
    logic [CNT_W-1:0]      out_count_q, out_count_d;
    logic [ERR_W-1:0]      err_count_q, err_count_d;
    logic [OUT_ADDR_W-1:0] first_err_q;
    logic                  end_seen_q;
    logic                  cmp_vld_q, cmp_extra_q;
    logic [DOUT_W-1:0]     cmp_data_q;
    logic [OUT_ADDR_W-1:0] cmp_idx_q;
    logic                  axis_en_q, dut_start_q;
    logic                  busy_q, done_q, pass_q, timeout_q;

    logic accept, is_extra, cmp_err, wd_fire, end_hit;

    always_comb begin
        accept   = (state_q == S_WAIT || state_q == S_FEED || state_q == S_DRAIN)
                   && o_valid && !out_stop;
        is_extra = (out_count_q >= OUT_FULL);
        // Extra beats still read a valid golden location; their compare result is forced to error.
        gold_addr   = is_extra ? GOLD_LAST : out_count_q[OUT_ADDR_W-1:0];
        cmp_err     = cmp_vld_q && (cmp_extra_q || (cmp_data_q != gold_rd_data));
        err_count_d = (cmp_err && err_count_q != '1) ? err_count_q + 1'b1 : err_count_q;
        out_count_d = (accept && out_count_q != '1) ? out_count_q + 1'b1 : out_count_q;
        wd_fire     = (state_q == S_FEED || state_q == S_DRAIN) && !accept && (wd_q == WD_LIMIT);
        end_hit     = end_seen_q || end_flag || (out_count_q == OUT_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            wait_q      <= '0;
            feed_q      <= '0;
            wd_q        <= '0;
            out_count_q <= '0;
            err_count_q <= '0;
            first_err_q <= '0;
            end_seen_q  <= 1'b0;
            cmp_vld_q   <= 1'b0;
            cmp_extra_q <= 1'b0;
            cmp_data_q  <= '0;
            cmp_idx_q   <= '0;
            axis_en_q   <= 1'b0;
            dut_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            cmp_vld_q   <= accept;
            cmp_extra_q <= is_extra;
            if (accept) begin
                cmp_data_q <= odata;
                cmp_idx_q  <= out_count_q[OUT_ADDR_W-1:0];
            end
            out_count_q <= out_count_d;
            err_count_q <= err_count_d;
            if (cmp_err && err_count_q == '0) begin
                first_err_q <= cmp_idx_q;
            end
            if ((state_q == S_WAIT || state_q == S_FEED) && end_flag) begin
                end_seen_q <= 1'b1;
            end
            axis_en_q   <= (state_q == S_FEED);
            dut_start_q <= 1'b0;

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        state_q     <= S_WAIT;
                        mode_q      <= stall_mode;
                        wait_q      <= '0;
                        feed_q      <= '0;
                        wd_q        <= '0;
                        out_count_q <= '0;
                        err_count_q <= '0;
                        first_err_q <= '0;
                        end_seen_q  <= 1'b0;
                        cmp_vld_q   <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                        dut_start_q <= (START_DELAY == 1);
                    end
                end
                S_WAIT: begin
                    if (wait_q == WT_LAST) begin
                        state_q <= S_FEED;
                    end else begin
                        wait_q      <= wait_q + 1'b1;
                        dut_start_q <= (wait_q + 1'b1 == WT_LAST);
                    end
                end
                S_FEED: begin
                    wd_q <= accept ? '0 : wd_q + 1'b1;
                    if (wd_fire) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_FLUSH;
                    end else if (feed_q == FEED_LAST) begin
                        state_q <= S_DRAIN;
                        wd_q    <= '0;
                    end else begin
                        feed_q <= feed_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    wd_q <= accept ? '0 : wd_q + 1'b1;
                    if (wd_fire) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_FLUSH;
                    end else if (end_hit) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // The last compare retires on this edge, so judge on its updated count.
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (err_count_d == '0) && (out_count_q == OUT_FULL) && !timeout_q;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    stall_gen #(
        .STALL_PERIOD (STALL_PERIOD),
        .STALL_LEN    (STALL_LEN)
    ) u_stall_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (busy_q),
        .mode     (mode_q),
        .out_stop (out_stop)
    );

    assign img_addr      = feed_q;
    assign axis_enable   = axis_en_q;
    assign s_axis_data   = axis_en_q ? img_rd_data : '0;
    assign dut_start     = dut_start_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_q;
    assign out_count     = out_count_q;

endmodule

// File: tb/tb_huff_stream_checker.sv
// Bench for huff_stream_checker: table of run scenarios driven through a queue-based DUT model.
module tb_huff_stream_checker;

    localparam int unsigned DIN_W = 8, DOUT_W = 15, IN_AW = 4, OUT_AW = 5, ERR_W = 16;
    localparam int unsigned FEED = 16, OUT_WORDS = 32;

    logic clk = 1'b0, rst_n = 1'b0, go = 1'b0;
    logic [1:0]        stall_mode = 2'd0;
    logic [IN_AW-1:0]  img_addr;
    logic [DIN_W-1:0]  img_rd_data;
    logic [OUT_AW-1:0] gold_addr;
    logic [DOUT_W-1:0] gold_rd_data;
    logic dut_start, axis_enable, out_stop, busy, done, pass, timeout;
    logic [DIN_W-1:0]  s_axis_data;
    logic [DOUT_W-1:0] odata = '0;
    logic o_valid = 1'b0, end_flag = 1'b0;
    logic [ERR_W-1:0]  err_count;
    logic [OUT_AW-1:0] first_err_idx;
    logic [OUT_AW:0]   out_count;

    always #5 clk = ~clk;

    huff_stream_checker #(
        .PIC_SIZE(4), .DIN_W(8), .DOUT_W(15), .IN_ADDR_W(4), .OUT_WORDS(32), .OUT_ADDR_W(5),
        .START_DELAY(3), .STALL_PERIOD(8), .STALL_LEN(3), .TIMEOUT_CYC(50), .ERR_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .stall_mode(stall_mode),
        .img_addr(img_addr), .img_rd_data(img_rd_data),
        .gold_addr(gold_addr), .gold_rd_data(gold_rd_data),
        .dut_start(dut_start), .axis_enable(axis_enable), .s_axis_data(s_axis_data),
        .out_stop(out_stop), .odata(odata), .o_valid(o_valid), .end_flag(end_flag),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_err_idx(first_err_idx), .out_count(out_count)
    );

    logic [DIN_W-1:0]  img_mem  [FEED];
    logic [DOUT_W-1:0] gold_mem [OUT_WORDS];

    always @(posedge clk) begin
        img_rd_data  <= img_mem[img_addr];
        gold_rd_data <= gold_mem[gold_addr];
    end

    wire [50:0] all_out = {img_addr, gold_addr, dut_start, axis_enable, s_axis_data, out_stop,
                           busy, done, pass, timeout, err_count, first_err_idx, out_count};

    int n_pass = 0, n_chk = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Golden word j, derived from pixel j/2 of the image.
    function automatic logic [DOUT_W-1:0] gfun(input logic [7:0] p, input int j);
        return {p, 7'(j)} ^ 15'(j * 97);
    endfunction

    typedef struct {
        logic [1:0] mode;
        int corrupt;
        int limit;
        bit send_end;
        bit regp;
        bit exp_pass;
        int exp_err;
        int exp_first;
        int exp_count;
        bit exp_to;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v, input int id);
        logic [DOUT_W-1:0] q[$];
        bit stops[$];
        int n = 0, pushed = 0, popped = 0, beats = 0, feed_bad = 0, track_bad = 0;
        int start_cnt = 0, start_at = -1, last_acc = -1, stop_hi = 0, stop_lo = 0, win_bad = 0;
        int prev_cnt = 0;
        bit prev_offer = 1'b0, prev_stop = 1'b0, seen_done = 1'b0;
        string tag;
        tag = $sformatf("v%0d", id);
        for (int i = 0; i < int'(FEED); i++) img_mem[i] = 8'($urandom);
        for (int j = 0; j < int'(OUT_WORDS); j++) gold_mem[j] = gfun(img_mem[j/2], j);
        @(negedge clk);
        stall_mode = v.mode;
        go = 1'b1;
        while (!seen_done && n < 400) begin
            @(negedge clk);
            n++;
            go = 1'b0;
            if (prev_offer && !prev_stop) begin
                void'(q.pop_front());
                popped++;
                last_acc = n - 1;
            end
            if (int'(out_count) - prev_cnt != int'(prev_offer && !prev_stop)) track_bad++;
            prev_cnt = int'(out_count);
            if (n == 1) check({tag, "_busy_done_start"}, longint'({busy, done}), 2);
            if (v.regp && n == 10) go = 1'b1;
            if (dut_start) begin start_cnt++; start_at = n; end
            if (busy) begin
                stops.push_back(out_stop);
                if (out_stop) stop_hi++; else stop_lo++;
            end
            if (axis_enable && beats < int'(FEED)) begin
                if (s_axis_data !== img_mem[beats]) feed_bad++;
                for (int k = 0; k < 2; k++) begin
                    if (pushed < v.limit) begin
                        q.push_back(gfun(s_axis_data, pushed) ^ ((pushed == v.corrupt) ? 15'd1 : 15'd0));
                        pushed++;
                    end
                end
                beats++;
                if (beats == int'(FEED) && pushed < v.limit) begin
                    q.push_back(gfun(8'd0, pushed));
                    pushed++;
                end
            end
            prev_offer = (q.size() > 0);
            prev_stop  = out_stop;
            o_valid  = prev_offer;
            odata    = prev_offer ? q[0] : '0;
            end_flag = v.send_end && prev_offer && !out_stop && (popped + 1 == v.limit);
            if (done) seen_done = 1'b1;
        end
        o_valid = 1'b0; end_flag = 1'b0; odata = '0;
        check({tag, "_done_reached"}, longint'(seen_done), 1);
        check({tag, "_dut_start_cycle"}, start_at, 3);
        check({tag, "_dut_start_pulses"}, start_cnt, 1);
        check({tag, "_feed_beats"}, beats, FEED);
        check({tag, "_feed_data_bad"}, feed_bad, 0);
        check({tag, "_accept_track_bad"}, track_bad, 0);
        check({tag, "_pass"}, longint'(pass), longint'(v.exp_pass));
        check({tag, "_err_count"}, longint'(err_count), v.exp_err);
        if (v.exp_first >= 0) check({tag, "_first_err_idx"}, longint'(first_err_idx), v.exp_first);
        check({tag, "_out_count"}, longint'(out_count), v.exp_count);
        check({tag, "_timeout"}, longint'(timeout), longint'(v.exp_to));
        check({tag, "_busy_after"}, longint'(busy), 0);
        if (v.exp_to) check({tag, "_timeout_latency_ok"}, longint'((n - last_acc) <= 52), 1);
        if (v.mode == 2'd1) begin
            for (int i = 8; i + 8 <= stops.size(); i++) begin
                int c = 0;
                for (int k = 0; k < 8; k++) c += int'(stops[i+k]);
                if (c != 3) win_bad++;
            end
            check({tag, "_periodic_windows_bad"}, win_bad, 0);
        end else if (v.mode == 2'd2) begin
            check({tag, "_lfsr_stalls_mixed"}, longint'(stop_hi > 0 && stop_lo > 0), 1);
        end else begin
            check({tag, "_stop_high_cycles"}, stop_hi, 0);
        end
    endtask

    initial begin
        int c7;
        c7 = int'($urandom_range(31, 0));
        vecs[0] = '{2'd0, -1, 32, 1'b1, 1'b0, 1'b1, 0, 0, 32, 1'b0};
        vecs[1] = '{2'd0,  5, 32, 1'b1, 1'b0, 1'b0, 1, 5, 32, 1'b0};
        vecs[2] = '{2'd1, -1, 32, 1'b1, 1'b0, 1'b1, 0, 0, 32, 1'b0};
        vecs[3] = '{2'd2, -1, 32, 1'b1, 1'b0, 1'b1, 0, 0, 32, 1'b0};
        vecs[4] = '{2'd3, -1, 32, 1'b1, 1'b0, 1'b1, 0, 0, 32, 1'b0};
        vecs[5] = '{2'd0, -1, 20, 1'b0, 1'b0, 1'b0, 0, 0, 20, 1'b1};
        vecs[6] = '{2'd0, -1, 33, 1'b1, 1'b0, 1'b0, 1, -1, 33, 1'b0};
        vecs[7] = '{2'd2, c7, 32, 1'b1, 1'b0, 1'b0, 1, c7, 32, 1'b0};
        vecs[8] = '{2'd0, -1, 32, 1'b1, 1'b1, 1'b1, 0, 0, 32, 1'b0};
        for (int i = 0; i < int'(FEED); i++) img_mem[i] = 8'($urandom);
        for (int j = 0; j < int'(OUT_WORDS); j++) gold_mem[j] = '0;

        repeat (3) @(negedge clk);
        check("reset_outputs_in_reset", longint'(all_out), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_outputs_after_release", longint'(all_out), 0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Asynchronous reset in the middle of FEED, then a clean restart.
        @(negedge clk);
        stall_mode = 2'd0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (6) @(negedge clk);
        check("midrun_busy", longint'(busy), 1);
        check("midrun_axis_enable", longint'(axis_enable), 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", longint'(all_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0], 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

endmodule
